// File: rtl/alu_share_ctrl_pkg.sv
// Shared ALU definitions: operation codes, data widths and the operand bundle.
package alu_share_ctrl_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned SEL_W   = 4;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [SEL_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_JALR = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [SEL_W-1:0] sel;
    } alu_req_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU; codes outside the defined set produce zero.
module alu
    import alu_share_ctrl_pkg::*;
(
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [SEL_W-1:0] sel,
    output logic [XLEN-1:0]  result_c
);

    logic [SHAMT_W-1:0] shamt_c;
    logic [XLEN-1:0]    sum_c;

    assign shamt_c = b[SHAMT_W-1:0];
    assign sum_c   = a + b;

    // Operation decode
    always_comb begin
        result_c = '0;
        case (sel)
            ALU_ADD:  result_c = sum_c;
            ALU_SUB:  result_c = a - b;
            ALU_AND:  result_c = a & b;
            ALU_OR:   result_c = a | b;
            ALU_XOR:  result_c = a ^ b;
            ALU_SLL:  result_c = a << shamt_c;
            ALU_SRL:  result_c = a >> shamt_c;
            ALU_SRA:  result_c = $unsigned($signed(a) >>> shamt_c);
            ALU_SLT:  result_c = XLEN'($signed(a) < $signed(b));
            ALU_SLTU: result_c = XLEN'(a < b);
            ALU_JALR: result_c = {sum_c[XLEN-1:1], 1'b0};
            default:  result_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Two-requester front end sharing one ALU with a single-entry result slot.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [XLEN-1:0]  req0_a,
    input  logic [XLEN-1:0]  req0_b,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [XLEN-1:0]  req1_a,
    input  logic [XLEN-1:0]  req1_b,
    input  logic [SEL_W-1:0] req1_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [XLEN-1:0]  rsp_data,
    output logic [CNT_W-1:0] acc_cnt0,
    output logic [CNT_W-1:0] acc_cnt1
);

    localparam logic PRIO0 = (FIXED_PRIO != 0);

    logic            last_gnt;
    logic            gnt0_c;
    logic            gnt1_c;
    logic            slot_free_c;
    logic            acc0_c;
    logic            acc1_c;
    alu_req_t        op_c;
    logic [XLEN-1:0] alu_y_c;

    // Grant from valids and last grant; accept needs a free result slot
    always_comb begin
        gnt0_c      = req0_valid & (~req1_valid | PRIO0 | last_gnt);
        gnt1_c      = req1_valid & ~gnt0_c;
        slot_free_c = ~rsp_valid | rsp_ready;
        acc0_c      = gnt0_c & slot_free_c;
        acc1_c      = gnt1_c & slot_free_c;
    end

    // Readies forced low while reset is held
    assign req0_ready = acc0_c & rst_n;
    assign req1_ready = acc1_c & rst_n;

    // Grant-selected operand mux into the shared ALU
    always_comb begin
        op_c = gnt1_c ? '{a: req1_a, b: req1_b, sel: req1_sel}
                      : '{a: req0_a, b: req0_b, sel: req0_sel};
    end

    alu u_alu (
        .a        (op_c.a),
        .b        (op_c.b),
        .sel      (op_c.sel),
        .result_c (alu_y_c)
    );

    // Result slot: load on accept, drain when consumed, hold under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
        end else if (acc0_c || acc1_c) begin
            rsp_valid <= 1'b1;
            rsp_id    <= acc1_c;
            rsp_data  <= alu_y_c;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Round-robin pointer tracks the most recent accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b0;
        end else if (acc0_c || acc1_c) begin
            last_gnt <= acc1_c;
        end
    end

    // Per-requester accept counters, wrapping naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt0 <= '0;
            acc_cnt1 <= '0;
        end else begin
            if (acc0_c) acc_cnt0 <= acc_cnt0 + CNT_W'(1);
            if (acc1_c) acc_cnt1 <= acc_cnt1 + CNT_W'(1);
        end
    end

endmodule
